block_fetch_queue: RTL and testbench
====================================

Name: block_fetch_queue

Overview:
- Parametrised successor to the single-skid block fetcher and two-entry block buffer.
- Issues block reads to the synchronous block memory with a configurable read latency, using credit-based flow control, and holds returned block words in a DEPTH-entry FIFO.
- Presents a ready/valid stream to instruction decode.
- Sits between the block instruction/register memories and the decode stage. Supports back-pressure at full throughput with no skid logic.

Parameters:
- data_width, 16, width of each register word
- n_blocks, 256, maximum number of blocks; address width is AW = $clog2(n_blocks)
- DEPTH, 4, FIFO entries (power of two, at least 2)
- READ_LATENCY, 1, cycles from block_read_addr to valid instr_in/register_*_in (1..4)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- enable  in  1  issue enable; gates new reads only
- n_blocks_running  in  AW  number of active blocks; 0 means idle
- block_read_addr  out  AW  block memory read address
- instr_in  in  32  instruction word from memory
- register_0_in  in  data_width  register 0 from memory
- register_1_in  in  data_width  register 1 from memory
- out_valid  out  1  head entry valid
- out_ready  in  1  consumer accepts head
- block_out  out  AW  block index of head
- instr_out  out  32  head instruction
- register_0_out  out  data_width  head register 0
- register_1_out  out  data_width  head register 1
- level  out  $clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (asynchronous):
  - block_read_addr=0, out_valid=0, level=0, in-flight pipe cleared.
  - block_out, instr_out, register_*_out = 0.
- Issue:
  - Fire when enable & n_blocks_running!=0 & (level + inflight) < DEPTH, where inflight is the count of valid issue-pipe stages.
  - A fire records block_read_addr in a READ_LATENCY-stage valid/index pipe, then advances the address.
- Address wrap:
  - If block_read_addr >= n_blocks_running-1, next address is 0; otherwise it increments by 1.
  - Round-robin runs 0..n-1 with no gaps.
- Capture:
  - Exactly READ_LATENCY cycles after a fire, push instr_in, register_0_in, register_1_in and the tagged index into the FIFO.
  - Capture is independent of enable, so in-flight data is never lost.
- Output:
  - out_* are driven from the FIFO head storage; out_valid = (level != 0).
  - Pop on out_valid & out_ready.
  - Minimum latency from fire to out_valid is READ_LATENCY+1 cycles.
- Simultaneous push and pop: level is unchanged and order is preserved.
- Credits: the credit rule guarantees a push never meets a full FIFO, so no overflow path exists.
- Throughput: with out_ready held high, one entry is delivered per cycle in steady state.
- Flush:
  - Triggered when n_blocks_running differs from its value registered last cycle, or when it equals 0.
  - Next cycle: level=0, out_valid=0, in-flight pipe invalidated, block_read_addr=0.
  - Issue may resume the cycle after that.
  - A pop in the flush cycle is allowed; data arriving for invalidated stages is discarded.
- enable low:
  - No fires; the address holds.
  - The FIFO still captures in-flight data and drains to the consumer.

Optional Feature:
- Macro: BLOCK_FETCH_LAST_MARK_EN.
- Enabled:
  - Adds output port last_block_out (1 bit), stored per FIFO entry.
  - Asserted on the entry whose block index equals n_blocks_running-1 at issue time, marking the end of a sample pass.
  - Resets to 0.
- Disabled: the port and its storage are absent; all other behaviour is identical.

Test Plan:
- Free run: n_blocks_running=3, READ_LATENCY=1, out_ready=1 -> after a 2-cycle start-up, block_out sequence is 0,1,2,0,1,2 with out_valid continuously high and instr_out matching the memory model per index.
- Stall: DEPTH=4, out_ready=0 for 10 cycles -> level saturates at 4, block_read_addr stops advancing; on release, entries 0,1,2,3 drain in order, none lost or duplicated.
- Latency sweep: READ_LATENCY=3, random out_ready 50% -> scoreboard shows every issued index delivered exactly once, in issue order, with data matching its index.
- Flush: n_blocks_running changes from 5 to 2 mid-stream with 3 entries queued -> next cycle out_valid=0 and level=0; the following sequence is 0,1,0,1.
- Async reset: reset asserted mid-burst between clock edges -> out_valid=0, level=0, block_read_addr=0 immediately, before the next clk edge.
- Last-block mark (macro enabled): n_blocks_running=4 -> last_block_out=1 only on entries with block_out=3.

Source files
------------

// File: rtl/block_fetch_queue_if.sv
// block_fetch_queue_if: issue control, memory read port and decode stream of the block
// fetch queue. The master modport is the fetch queue. The slave modport is its environment.
// When BLOCK_FETCH_LAST_MARK_EN is defined, the interface also carries last_block_out.
interface block_fetch_queue_if #(
    parameter int unsigned data_width = 16,
    parameter int unsigned n_blocks   = 256,
    parameter int unsigned DEPTH      = 4
);
    localparam int unsigned AW = $clog2(n_blocks);
    localparam int unsigned LW = $clog2(DEPTH) + 1;

    logic                  enable;
    logic [AW-1:0]         n_blocks_running;
    logic [AW-1:0]         block_read_addr;
    logic [31:0]           instr_in;
    logic [data_width-1:0] register_0_in;
    logic [data_width-1:0] register_1_in;
    logic                  out_valid;
    logic                  out_ready;
    logic [AW-1:0]         block_out;
    logic [31:0]           instr_out;
    logic [data_width-1:0] register_0_out;
    logic [data_width-1:0] register_1_out;
    logic [LW-1:0]         level;
`ifdef BLOCK_FETCH_LAST_MARK_EN
    logic                  last_block_out;
`endif

    modport master (
        input  enable, n_blocks_running, instr_in, register_0_in, register_1_in, out_ready,
`ifdef BLOCK_FETCH_LAST_MARK_EN
        output last_block_out,
`endif
        output block_read_addr, out_valid, block_out, instr_out, register_0_out,
               register_1_out, level
    );

    modport slave (
        output enable, n_blocks_running, instr_in, register_0_in, register_1_in, out_ready,
`ifdef BLOCK_FETCH_LAST_MARK_EN
        input  last_block_out,
`endif
        input  block_read_addr, out_valid, block_out, instr_out, register_0_out,
               register_1_out, level
    );
endinterface

// File: rtl/block_fetch_queue.sv
// block_fetch_queue: issues round-robin block reads to a memory with fixed read latency.
// Credits cover the FIFO occupancy plus the in-flight reads.
// Returned words are queued in a DEPTH-entry FIFO that feeds a ready/valid decode stream.
// If BLOCK_FETCH_LAST_MARK_EN is defined, each entry also carries a last-block flag.
module block_fetch_queue #(
    parameter int unsigned data_width   = 16,
    parameter int unsigned n_blocks     = 256,
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned READ_LATENCY = 1
) (
    input logic                 clk,
    input logic                 reset,
    block_fetch_queue_if.master bus
);
    localparam int unsigned AW = $clog2(n_blocks);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned LW = PW + 1;

    logic [AW-1:0]           addr_q;
    logic [AW-1:0]           n_prev_q;
    logic [AW-1:0]           n_last;
    logic [READ_LATENCY-1:0] pipe_vld_q;
    logic [AW-1:0]           pipe_idx_q [READ_LATENCY];
    logic [AW-1:0]           fifo_blk_q [DEPTH];
    logic [31:0]             fifo_instr_q [DEPTH];
    logic [data_width-1:0]   fifo_r0_q [DEPTH];
    logic [data_width-1:0]   fifo_r1_q [DEPTH];
`ifdef BLOCK_FETCH_LAST_MARK_EN
    logic [READ_LATENCY-1:0] pipe_last_q;
    logic                    fifo_last_q [DEPTH];
`endif
    logic [PW-1:0]           wr_ptr_q;
    logic [PW-1:0]           rd_ptr_q;
    logic [LW-1:0]           level_q;
    logic                    flush;
    logic                    credit_ok;
    logic                    fire;
    logic                    push;
    logic                    pop;
    int unsigned             inflight;

    // Flush detection, credit check and FIFO handshake decode.
    always_comb begin
        inflight = 0;
        for (int i = 0; i < int'(READ_LATENCY); i++) begin
            inflight += 32'(pipe_vld_q[i]);
        end
        n_last    = bus.n_blocks_running - AW'(1);
        flush     = (bus.n_blocks_running != n_prev_q) || (bus.n_blocks_running == '0);
        credit_ok = (32'(level_q) + inflight) < DEPTH;
        fire      = bus.enable && !flush && credit_ok;
        // Returns for stages killed by a flush are dropped.
        push      = pipe_vld_q[READ_LATENCY-1] && !flush;
        pop       = (level_q != '0) && bus.out_ready;
    end

    // Read address, running-count history and the tagged issue pipe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q     <= '0;
            n_prev_q   <= '0;
            pipe_vld_q <= '0;
            for (int i = 0; i < int'(READ_LATENCY); i++) pipe_idx_q[i] <= '0;
`ifdef BLOCK_FETCH_LAST_MARK_EN
            pipe_last_q <= '0;
`endif
        end else begin
            n_prev_q <= bus.n_blocks_running;
            if (flush) begin
                addr_q     <= '0;
                pipe_vld_q <= '0;
            end else begin
                pipe_vld_q[0] <= fire;
                for (int i = 1; i < int'(READ_LATENCY); i++) pipe_vld_q[i] <= pipe_vld_q[i-1];
                if (fire) addr_q <= (addr_q >= n_last) ? '0 : addr_q + AW'(1);
            end
            pipe_idx_q[0] <= addr_q;
            for (int i = 1; i < int'(READ_LATENCY); i++) pipe_idx_q[i] <= pipe_idx_q[i-1];
`ifdef BLOCK_FETCH_LAST_MARK_EN
            pipe_last_q[0] <= (addr_q == n_last);
            for (int i = 1; i < int'(READ_LATENCY); i++) pipe_last_q[i] <= pipe_last_q[i-1];
`endif
        end
    end

    // FIFO storage, pointers and occupancy.
    // A push never meets a full FIFO because credits include in-flight reads.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                fifo_blk_q[i]   <= '0;
                fifo_instr_q[i] <= '0;
                fifo_r0_q[i]    <= '0;
                fifo_r1_q[i]    <= '0;
`ifdef BLOCK_FETCH_LAST_MARK_EN
                fifo_last_q[i]  <= 1'b0;
`endif
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) begin
                fifo_blk_q[wr_ptr_q]   <= pipe_idx_q[READ_LATENCY-1];
                fifo_instr_q[wr_ptr_q] <= bus.instr_in;
                fifo_r0_q[wr_ptr_q]    <= bus.register_0_in;
                fifo_r1_q[wr_ptr_q]    <= bus.register_1_in;
`ifdef BLOCK_FETCH_LAST_MARK_EN
                fifo_last_q[wr_ptr_q]  <= pipe_last_q[READ_LATENCY-1];
`endif
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
            level_q <= level_q + LW'(push) - LW'(pop);
        end
    end

    assign bus.block_read_addr = addr_q;
    assign bus.out_valid       = (level_q != '0);
    assign bus.block_out       = fifo_blk_q[rd_ptr_q];
    assign bus.instr_out       = fifo_instr_q[rd_ptr_q];
    assign bus.register_0_out  = fifo_r0_q[rd_ptr_q];
    assign bus.register_1_out  = fifo_r1_q[rd_ptr_q];
    assign bus.level           = level_q;
`ifdef BLOCK_FETCH_LAST_MARK_EN
    assign bus.last_block_out  = fifo_last_q[rd_ptr_q];
`endif
endmodule

// File: tb/tb_block_fetch_queue.sv
// tb_block_fetch_queue: self-checking bench for block_fetch_queue.
// Two instances (READ_LATENCY 1 and 3) share the same stimulus.
// Each instance has its own latency-accurate memory model.
module tb_block_fetch_queue;
    localparam int unsigned DW    = 16;
    localparam int unsigned NB    = 256;
    localparam int unsigned DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic [7:0] nbr = 8'd0;
    logic       rdy = 1'b0;
    int         checks = 0;
    int         errors = 0;

    block_fetch_queue_if #(.data_width(DW), .n_blocks(NB), .DEPTH(DEPTH)) bus1 ();
    block_fetch_queue_if #(.data_width(DW), .n_blocks(NB), .DEPTH(DEPTH)) bus3 ();

    block_fetch_queue #(.data_width(DW), .n_blocks(NB), .DEPTH(DEPTH), .READ_LATENCY(1)) u_dut1 (
        .clk(clk), .reset(reset), .bus(bus1));
    block_fetch_queue #(.data_width(DW), .n_blocks(NB), .DEPTH(DEPTH), .READ_LATENCY(3)) u_dut3 (
        .clk(clk), .reset(reset), .bus(bus3));

    always #5 clk = ~clk;

    // Memory contents as a fixed function of block index.
    function automatic logic [31:0] m_instr(input logic [7:0] a);
        return {8'hC0, a, ~a, a ^ 8'h5A};
    endfunction
    function automatic logic [15:0] m_r0(input logic [7:0] a);
        return {a, a ^ 8'h3C};
    endfunction
    function automatic logic [15:0] m_r1(input logic [7:0] a);
        return {~a, a + 8'd7};
    endfunction

    // Synchronous memories: data appears READ_LATENCY cycles after the address.
    logic [7:0] mp1;
    logic [7:0] mp3 [3];
    always @(posedge clk) begin
        mp1    <= bus1.block_read_addr;
        mp3[0] <= bus3.block_read_addr;
        mp3[1] <= mp3[0];
        mp3[2] <= mp3[1];
    end

    assign bus1.enable = enable;
    assign bus1.n_blocks_running = nbr;
    assign bus1.out_ready = rdy;
    assign bus1.instr_in = m_instr(mp1);
    assign bus1.register_0_in = m_r0(mp1);
    assign bus1.register_1_in = m_r1(mp1);
    assign bus3.enable = enable;
    assign bus3.n_blocks_running = nbr;
    assign bus3.out_ready = rdy;
    assign bus3.instr_in = m_instr(mp3[2]);
    assign bus3.register_0_in = m_r0(mp3[2]);
    assign bus3.register_1_in = m_r1(mp3[2]);

    task automatic test_reset();
        reset = 1'b1; enable = 1'b0; nbr = 8'd0; rdy = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (bus1.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b want 0", bus1.out_valid); end
        checks++; if (bus1.level !== 3'd0) begin errors++; $display("FAIL reset_level got %0d want 0", bus1.level); end
        checks++; if (bus1.block_read_addr !== 8'd0) begin errors++; $display("FAIL reset_addr got %0d want 0", bus1.block_read_addr); end
        checks++; if (bus1.block_out !== 8'd0) begin errors++; $display("FAIL reset_block_out got %0d want 0", bus1.block_out); end
        checks++; if (bus1.instr_out !== 32'd0) begin errors++; $display("FAIL reset_instr_out got %h want 0", bus1.instr_out); end
        checks++; if (bus1.register_0_out !== 16'd0) begin errors++; $display("FAIL reset_r0 got %h want 0", bus1.register_0_out); end
        checks++; if (bus1.register_1_out !== 16'd0) begin errors++; $display("FAIL reset_r1 got %h want 0", bus1.register_1_out); end
        checks++; if (bus3.out_valid !== 1'b0 || bus3.level !== 3'd0) begin errors++; $display("FAIL reset_dut3 got valid=%0b level=%0d want 0/0", bus3.out_valid, bus3.level); end
    endtask

    task automatic test_free_run();
        int w;
        int e;
        nbr = 8'd3; enable = 1'b1; rdy = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        w = 0;
        while (bus1.out_valid !== 1'b1 && w < 20) begin @(negedge clk); w++; end
        checks++; if (w >= 20) begin errors++; $display("FAIL free_run_startup got no out_valid within 20 cycles want valid"); end
        e = 0;
        for (int i = 0; i < 12; i++) begin
            checks++; if (bus1.out_valid !== 1'b1) begin errors++; $display("FAIL free_run_valid cycle %0d got %0b want 1", i, bus1.out_valid); end
            checks++; if (bus1.block_out !== 8'(e)) begin errors++; $display("FAIL free_run_block cycle %0d got %0d want %0d", i, bus1.block_out, e); end
            checks++; if (bus1.instr_out !== m_instr(8'(e))) begin errors++; $display("FAIL free_run_instr cycle %0d got %h want %h", i, bus1.instr_out, m_instr(8'(e))); end
            e = (e + 1) % 3;
            @(negedge clk);
        end
    endtask

    task automatic test_stall();
        logic [7:0] a_hold;
        rdy = 1'b0; nbr = 8'd6;
        repeat (11) @(negedge clk);
        checks++; if (bus1.level !== 3'd4) begin errors++; $display("FAIL stall_level1 got %0d want 4", bus1.level); end
        checks++; if (bus3.level !== 3'd4) begin errors++; $display("FAIL stall_level3 got %0d want 4", bus3.level); end
        a_hold = 8'd4;
        repeat (3) @(negedge clk);
        checks++; if (bus1.block_read_addr !== a_hold) begin errors++; $display("FAIL stall_addr1 got %0d want %0d", bus1.block_read_addr, a_hold); end
        checks++; if (bus3.block_read_addr !== a_hold) begin errors++; $display("FAIL stall_addr3 got %0d want %0d", bus3.block_read_addr, a_hold); end
        enable = 1'b0; rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++; if (bus1.out_valid !== 1'b1 || bus1.block_out !== 8'(i)) begin errors++; $display("FAIL stall_drain1 %0d got v=%0b blk=%0d want 1/%0d", i, bus1.out_valid, bus1.block_out, i); end
            checks++; if (bus1.register_0_out !== m_r0(8'(i))) begin errors++; $display("FAIL stall_drain_r0 %0d got %h want %h", i, bus1.register_0_out, m_r0(8'(i))); end
            checks++; if (bus3.out_valid !== 1'b1 || bus3.block_out !== 8'(i)) begin errors++; $display("FAIL stall_drain3 %0d got v=%0b blk=%0d want 1/%0d", i, bus3.out_valid, bus3.block_out, i); end
            @(negedge clk);
        end
        checks++; if (bus1.out_valid !== 1'b0 || bus1.level !== 3'd0) begin errors++; $display("FAIL stall_empty got v=%0b level=%0d want 0/0", bus1.out_valid, bus1.level); end
        repeat (2) @(negedge clk);
        checks++; if (bus1.block_read_addr !== a_hold) begin errors++; $display("FAIL enable_low_addr got %0d want %0d", bus1.block_read_addr, a_hold); end
    endtask

    task automatic test_flush();
        int w;
        int e;
        int got;
        enable = 1'b1; rdy = 1'b0; nbr = 8'd5;
        w = 0;
        while (bus1.level !== 3'd3 && w < 20) begin @(negedge clk); w++; end
        checks++; if (w >= 20) begin errors++; $display("FAIL flush_fill got level %0d want 3", bus1.level); end
        rdy = 1'b1; nbr = 8'd2;
        @(negedge clk);
        checks++; if (bus1.out_valid !== 1'b0 || bus1.level !== 3'd0) begin errors++; $display("FAIL flush_clear1 got v=%0b level=%0d want 0/0", bus1.out_valid, bus1.level); end
        checks++; if (bus1.block_read_addr !== 8'd0) begin errors++; $display("FAIL flush_addr got %0d want 0", bus1.block_read_addr); end
        checks++; if (bus3.out_valid !== 1'b0 || bus3.level !== 3'd0) begin errors++; $display("FAIL flush_clear3 got v=%0b level=%0d want 0/0", bus3.out_valid, bus3.level); end
        e = 0; got = 0; w = 0;
        while (got < 4 && w < 20) begin
            if (bus1.out_valid === 1'b1) begin
                checks++; if (bus1.block_out !== 8'(e)) begin errors++; $display("FAIL flush_seq %0d got %0d want %0d", got, bus1.block_out, e); end
                checks++; if (bus1.register_1_out !== m_r1(8'(e))) begin errors++; $display("FAIL flush_r1 %0d got %h want %h", got, bus1.register_1_out, m_r1(8'(e))); end
                e = e ^ 1;
                got++;
            end
            @(negedge clk);
            w++;
        end
        checks++; if (got != 4) begin errors++; $display("FAIL flush_count got %0d want 4", got); end
    endtask

    task automatic test_latency_sweep();
        int e1, e3, p3, n_cur, n_new;
        e1 = 0; e3 = 0; p3 = 0; n_cur = 4;
        for (int cyc = 0; cyc < 500; cyc++) begin
            n_new = n_cur;
            if (cyc >= 485) begin
                enable = 1'b0; rdy = 1'b1;
            end else begin
                enable = ($urandom % 5) != 0;
                rdy = ($urandom % 2) == 1;
                if (cyc == 0 || ($urandom % 64) == 0) n_new = 3 + int'($urandom % 5);
                if (cyc == 0) n_new = 4;
            end
            nbr = 8'(n_new);
            // The first cycle's pops belong to the stream left by the previous test.
            if (cyc > 0) begin
                checks++; if (bus3.level > 3'd4) begin errors++; $display("FAIL sweep_level3 got %0d want <=4", bus3.level); end
                if (bus1.out_valid === 1'b1 && rdy) begin
                    checks++; if (bus1.block_out !== 8'(e1) || bus1.instr_out !== m_instr(8'(e1))) begin errors++; $display("FAIL sweep_dut1 cyc %0d got %0d/%h want %0d/%h", cyc, bus1.block_out, bus1.instr_out, e1, m_instr(8'(e1))); end
                    e1 = (e1 + 1) % n_cur;
                end
                if (bus3.out_valid === 1'b1 && rdy) begin
                    checks++; if (bus3.block_out !== 8'(e3) || bus3.instr_out !== m_instr(8'(e3)) || bus3.register_0_out !== m_r0(8'(e3))) begin errors++; $display("FAIL sweep_dut3 cyc %0d got %0d/%h want %0d/%h", cyc, bus3.block_out, bus3.instr_out, e3, m_instr(8'(e3))); end
                    e3 = (e3 + 1) % n_cur;
                    p3++;
                end
            end
            if (cyc == 0 || n_new != n_cur) begin
                e1 = 0; e3 = 0; n_cur = n_new;
            end
            @(negedge clk);
        end
        checks++; if (bus1.level !== 3'd0 || bus3.level !== 3'd0) begin errors++; $display("FAIL sweep_drain got %0d/%0d want 0/0", bus1.level, bus3.level); end
        checks++; if (bus1.block_read_addr !== 8'(e1)) begin errors++; $display("FAIL sweep_issued1 got addr %0d want %0d", bus1.block_read_addr, e1); end
        checks++; if (bus3.block_read_addr !== 8'(e3)) begin errors++; $display("FAIL sweep_issued3 got addr %0d want %0d", bus3.block_read_addr, e3); end
        checks++; if (p3 < 40) begin errors++; $display("FAIL sweep_throughput got %0d pops want >=40", p3); end
    endtask

    task automatic test_async_reset();
        nbr = 8'd4; enable = 1'b1; rdy = 1'b1;
        repeat (8) @(negedge clk);
        @(posedge clk);
        #1;
        checks++; if (bus1.out_valid !== 1'b1) begin errors++; $display("FAIL areset_pre got v=%0b want 1", bus1.out_valid); end
        #1 reset = 1'b1;
        #1;
        checks++; if (bus1.out_valid !== 1'b0 || bus1.level !== 3'd0 || bus1.block_read_addr !== 8'd0) begin errors++; $display("FAIL areset_dut1 got v=%0b l=%0d a=%0d want 0/0/0", bus1.out_valid, bus1.level, bus1.block_read_addr); end
        checks++; if (bus3.out_valid !== 1'b0 || bus3.level !== 3'd0 || bus3.block_read_addr !== 8'd0) begin errors++; $display("FAIL areset_dut3 got v=%0b l=%0d a=%0d want 0/0/0", bus3.out_valid, bus3.level, bus3.block_read_addr); end
        @(negedge clk);
        reset = 1'b0;
    endtask

`ifdef BLOCK_FETCH_LAST_MARK_EN
    task automatic test_last_mark();
        int e;
        int seen;
        e = 0; seen = 0;
        nbr = 8'd4; enable = 1'b1; rdy = 1'b1;
        for (int i = 0; i < 30; i++) begin
            if (bus1.out_valid === 1'b1) begin
                checks++; if (bus1.block_out !== 8'(e) || bus1.last_block_out !== (e == 3)) begin errors++; $display("FAIL last_mark got blk=%0d last=%0b want %0d/%0b", bus1.block_out, bus1.last_block_out, e, (e == 3)); end
                if (e == 3) seen++;
                e = (e + 1) % 4;
            end
            @(negedge clk);
        end
        checks++; if (seen < 3) begin errors++; $display("FAIL last_mark_seen got %0d want >=3", seen); end
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_free_run();
        test_stall();
        test_flush();
        test_latency_sweep();
        test_async_reset();
`ifdef BLOCK_FETCH_LAST_MARK_EN
        test_last_mark();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
